// File: rtl/array_sweep_if.sv
// Control, status and readback bundle for array_sweep.
// The bench/harness drives through master; the engine sits on slave.
interface array_sweep_if #(
    parameter int IDX_W  = 2,
    parameter int CNT_W  = 7,
    parameter int HIST_W = 1
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [63:0]       cycles;
    logic [IDX_W-1:0]  rd_idx;
    logic [CNT_W-1:0]  rd_data;
    logic [HIST_W-1:0] hist_target;

    modport master (output start, abort, rd_idx,
                    input  busy, done, cycles, rd_data, hist_target);
    modport slave  (input  start, abort, rd_idx,
                    output busy, done, cycles, rd_data, hist_target);
endinterface

// File: rtl/array_sweep.sv
// Array-stress engine: a pointer sweeps a counter memory while the last entry feeds a histogram.
// Optional macro ARRAY_SWEEP_DISPLAY_EN prints the cycle count and calls $finish on completion.
module array_sweep #(
    parameter int IDX_W    = 2,
    parameter int CNT_W    = 3*IDX_W+1,
    parameter int HIST_SEL = 3,
    parameter int HIST_W   = 1,
    parameter int TARGET   = 4,
    parameter int THRESH   = 1,
    parameter int FINISH   = 0
) (
    input  logic         clock,
    input  logic         reset_n,
    array_sweep_if.slave bus
);
    localparam int DEPTH = 2**IDX_W;
    localparam int NBIN  = 2**HIST_SEL;
    localparam logic [HIST_SEL-1:0] TGT = HIST_SEL'(TARGET);
    localparam logic [HIST_W-1:0]   THR = HIST_W'(THRESH);

    if (HIST_SEL < 2 || HIST_SEL > CNT_W) begin : g_bad_sel
        $error("array_sweep: HIST_SEL must be in 2..CNT_W");
    end
    if (TARGET < 0 || TARGET >= NBIN) begin : g_bad_tgt
        $error("array_sweep: TARGET must be below 2**HIST_SEL");
    end
    if (THRESH < 1 || THRESH > 2**HIST_W-1) begin : g_bad_thr
        $error("array_sweep: THRESH must be in 1..2**HIST_W-1");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [IDX_W-1:0]              r_ptr;
    logic [DEPTH-1:0][CNT_W-1:0]   r_mem;
    logic [NBIN-1:0][HIST_W-1:0]   r_hist;
    logic [63:0]                   r_cycles;
    logic                          w_clear;
    logic                          w_step;
    logic                          w_hit;
    logic [HIST_SEL-1:0]           w_bin;

    // Bin comes from the pre-edge last entry, so a same-edge write to it is not seen.
    assign w_bin = {r_mem[DEPTH-1][CNT_W-1], r_mem[DEPTH-1][HIST_SEL-2:0]};
    assign w_hit = (r_hist[TGT] >= THR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort)  w_state_nxt = S_IDLE;
                else if (w_hit) w_state_nxt = S_DONE;
                else            w_step      = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr    <= '0;
            r_mem    <= '0;
            r_hist   <= '0;
            r_cycles <= '0;
        end else begin
            if (w_clear) begin
                r_ptr    <= '0;
                r_mem    <= '0;
                r_hist   <= '0;
                r_cycles <= '0;
            end else if (w_step) begin
                r_ptr         <= r_ptr + IDX_W'(1);
                r_mem[r_ptr]  <= r_mem[r_ptr] + CNT_W'(1);
                r_hist[w_bin] <= r_hist[w_bin] + HIST_W'(1);
                r_cycles      <= r_cycles + 64'd1;
            end
`ifdef ARRAY_SWEEP_DISPLAY_EN
            if (r_state == S_RUN && w_state_nxt == S_DONE) begin
                $display("%0d", r_cycles);
                $finish(FINISH);
            end
`endif
        end
    end

    assign bus.busy        = (r_state == S_RUN);
    assign bus.done        = (r_state == S_DONE);
    assign bus.cycles      = r_cycles;
    assign bus.rd_data     = r_mem[bus.rd_idx];
    assign bus.hist_target = r_hist[TGT];
endmodule

// File: tb/tb_array_sweep.sv
// Scoreboard bench for array_sweep: three parameterisations, runs, abort, async reset and DONE hold.
module tb_array_sweep;
    logic clock;
    logic reset_n;
    int   n_chk = 0;
    int   n_err = 0;

    typedef struct {
        logic [63:0] cyc;
        logic [63:0] hist;
        bit          has_rd;
        logic [63:0] rd3;
        logic [63:0] rd0;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    array_sweep_if #(.IDX_W(2), .CNT_W(7),  .HIST_W(1)) if0 ();
    array_sweep_if #(.IDX_W(2), .CNT_W(7),  .HIST_W(2)) if1 ();
    array_sweep_if #(.IDX_W(3), .CNT_W(10), .HIST_W(1)) if2 ();

    array_sweep u_dut0 (.clock(clock), .reset_n(reset_n), .bus(if0));
    array_sweep #(.HIST_W(2), .THRESH(2)) u_dut1 (.clock(clock), .reset_n(reset_n), .bus(if1));
    array_sweep #(.IDX_W(3), .CNT_W(10), .HIST_SEL(4), .TARGET(8))
        u_dut2 (.clock(clock), .reset_n(reset_n), .bus(if2));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic get_done(input int w);
        case (w)
            0:       return if0.done;
            1:       return if1.done;
            default: return if2.done;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            0:       return if0.busy;
            1:       return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    function automatic logic [63:0] get_cycles(input int w);
        case (w)
            0:       return if0.cycles;
            1:       return if1.cycles;
            default: return if2.cycles;
        endcase
    endfunction

    function automatic logic [63:0] get_hist(input int w);
        case (w)
            0:       return 64'(if0.hist_target);
            1:       return 64'(if1.hist_target);
            default: return 64'(if2.hist_target);
        endcase
    endfunction

    task automatic pulse_start(input bit ab);
        @(posedge clock); #1;
        if0.start = 1'b1; if0.abort = ab;
        @(posedge clock); #1;
        if0.start = 1'b0; if0.abort = 1'b0;
    endtask

    // Counts RUN edges (negedges seen busy) until done, bounded by budget.
    task automatic wait_done(input int w, input int budget, output int nbusy, output bit ok);
        nbusy = 0;
        ok    = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (get_done(w)) begin
                ok = 1'b1;
                break;
            end
            if (get_busy(w)) nbusy++;
        end
    endtask

    task automatic check_result(input int w, input string tag);
        exp_t e;
        bit   have = 1'b0;
        case (w)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        chk({tag, "_sb"}, 64'(have), 64'd1);
        if (have) begin
            chk({tag, "_cycles"}, get_cycles(w), e.cyc);
            chk({tag, "_hist"}, get_hist(w), e.hist);
            if (e.has_rd) begin
                if0.rd_idx = 2'd3; #1;
                chk({tag, "_rd3"}, 64'(if0.rd_data), e.rd3);
                if0.rd_idx = 2'd0; #1;
                chk({tag, "_rd0"}, 64'(if0.rd_data), e.rd0);
            end
        end
    endtask

    task automatic run_and_check(input int w, input string tag, input int budget, input int exp_edges);
        int n;
        bit ok;
        wait_done(w, budget, n, ok);
        chk({tag, "_timeout"}, 64'(ok), 64'd1);
        if (exp_edges >= 0) chk({tag, "_edges"}, 64'(n), 64'(exp_edges));
        check_result(w, tag);
    endtask

    function automatic exp_t mk0(input logic [63:0] cyc);
        exp_t e;
        e.cyc = cyc; e.hist = 64'd1; e.has_rd = 1'b1; e.rd3 = 64'd64; e.rd0 = 64'd65;
        return e;
    endfunction

    initial begin
        exp_t e;
        int   n1, n2;
        bit   ok1, ok2;

        reset_n = 1'b1;
        if0.start = 1'b0; if0.abort = 1'b0; if0.rd_idx = '0;
        if1.start = 1'b0; if1.abort = 1'b0; if1.rd_idx = '0;
        if2.start = 1'b0; if2.abort = 1'b0; if2.rd_idx = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy",   64'(if0.busy), 64'd0);
        chk("rst_done",   64'(if0.done), 64'd0);
        chk("rst_cycles", if0.cycles, 64'd0);
        chk("rst_rd",     64'(if0.rd_data), 64'd0);
        chk("rst_hist",   64'(if0.hist_target), 64'd0);
        #9 reset_n = 1'b1;

        // Default full run.
        q0.push_back(mk0(64'd257));
        pulse_start(1'b0);
        chk("run0_busy", 64'(if0.busy), 64'd1);
        run_and_check(0, "run0", 1000, 258);

        // DONE holds its state.
        repeat (5) @(posedge clock);
        #1;
        chk("hold_done",   64'(if0.done), 64'd1);
        chk("hold_cycles", if0.cycles, 64'd257);

        // THRESH=2 and the wider memory, run side by side.
        e.cyc = 64'd258;  e.hist = 64'd2; e.has_rd = 1'b0; e.rd3 = '0; e.rd0 = '0;
        q1.push_back(e);
        e.cyc = 64'd4097; e.hist = 64'd1;
        q2.push_back(e);
        @(posedge clock); #1;
        if1.start = 1'b1; if2.start = 1'b1;
        @(posedge clock); #1;
        if1.start = 1'b0; if2.start = 1'b0;
        fork
            wait_done(1, 1000, n1, ok1);
            wait_done(2, 6000, n2, ok2);
        join
        chk("thr2_timeout", 64'(ok1), 64'd1);
        chk("thr2_edges", 64'(n1), 64'd259);
        check_result(1, "thr2");
        chk("wide_timeout", 64'(ok2), 64'd1);
        chk("wide_edges", 64'(n2), 64'd4098);
        check_result(2, "wide");

        // Abort on RUN edge 100, starting from DONE.
        pulse_start(1'b0);
        chk("ab_done_clr", 64'(if0.done), 64'd0);
        repeat (99) @(posedge clock);
        #1 if0.abort = 1'b1;
        @(posedge clock); #1;
        if0.abort = 1'b0;
        chk("ab_busy",   64'(if0.busy), 64'd0);
        chk("ab_done",   64'(if0.done), 64'd0);
        chk("ab_cycles", if0.cycles, 64'd99);
        if0.rd_idx = 2'd0; #1;
        chk("ab_rd0", 64'(if0.rd_data), 64'd25);
        repeat (3) @(posedge clock);
        #1 chk("ab_frozen", if0.cycles, 64'd99);

        // Start wins over abort in IDLE; a start during RUN is ignored.
        q0.push_back(mk0(64'd257));
        pulse_start(1'b1);
        chk("prio_busy", 64'(if0.busy), 64'd1);
        repeat (50) @(posedge clock);
        #1 if0.start = 1'b1;
        @(posedge clock); #1;
        if0.start = 1'b0;
        run_and_check(0, "rerun", 1000, -1);

        // Asynchronous reset mid-run clears outputs without a clock edge.
        pulse_start(1'b0);
        repeat (149) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_busy",   64'(if0.busy), 64'd0);
        chk("arst_done",   64'(if0.done), 64'd0);
        chk("arst_cycles", if0.cycles, 64'd0);
        chk("arst_rd",     64'(if0.rd_data), 64'd0);
        #3 reset_n = 1'b1;
        q0.push_back(mk0(64'd257));
        pulse_start(1'b0);
        run_and_check(0, "post_rst", 1000, 258);

        chk("sb_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
